// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its execution engine.
// result_t is the 64-bit signed result produced by instr_alu / instr_exec.
package instr_register_pkg;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic signed [63:0] result_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

endpackage

// File: rtl/instr_alu.sv
// Combinational arithmetic for one instruction; operands sign-extended to 64 bits.
// DIV/MOD are only built when INSTR_EXEC_DIV_EN is defined, otherwise they yield 0.
module instr_alu
    import instr_register_pkg::*;
(
    input  instruction_t instr,
    output result_t      result,
    output logic         div_by_zero
);

    result_t a;
    result_t b;

    always_comb begin
        a           = {{32{instr.op_a[31]}}, instr.op_a};
        b           = {{32{instr.op_b[31]}}, instr.op_b};
        result      = '0;
        div_by_zero = 1'b0;
        case (instr.opc)
            ZERO:  result = '0;
            PASSA: result = a;
            PASSB: result = b;
            ADD:   result = a + b;
            SUB:   result = a - b;
            MULT:  result = a * b;
`ifdef INSTR_EXEC_DIV_EN
            // Signed '/' truncates toward zero and '%' follows the dividend's sign.
            DIV: begin
                if (b == '0) div_by_zero = 1'b1;
                else         result      = a / b;
            end
            MOD: begin
                if (b == '0) div_by_zero = 1'b1;
                else         result      = a % b;
            end
`else
            DIV:   result = '0;
            MOD:   result = '0;
`endif
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/instr_exec.sv
// Batch executor: fetches instructions from an instr_register, runs them through
// instr_alu and presents each result with a valid/ready handshake. Macro: INSTR_EXEC_DIV_EN.
module instr_exec
    import instr_register_pkg::*;
#(
    parameter int PTR_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [PTR_W-1:0] start_ptr,
    input  logic [PTR_W:0]   count,
    output logic [PTR_W-1:0] read_pointer,
    input  instruction_t     instruction_word,
    output result_t          result,
    output opcode_t          res_opcode,
    output logic [PTR_W-1:0] res_ptr,
    output logic             div_by_zero,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, OUT} state_t;

    localparam logic [PTR_W:0]   REM_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    state_t           state_reg, state_next;
    logic [PTR_W-1:0] ptr_reg;
    logic [PTR_W:0]   remaining_reg;
    instruction_t     instr_reg;
    result_t          result_reg;
    opcode_t          res_opcode_reg;
    logic [PTR_W-1:0] res_ptr_reg;
    logic             dbz_reg;
    logic             done_reg;
    result_t          alu_result;
    logic             alu_dbz;
    logic             launch;

    assign launch = (state_reg == IDLE) && start && (count != '0);

    instr_alu u_alu (
        .instr       (instr_reg),
        .result      (alu_result),
        .div_by_zero (alu_dbz)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (launch) state_next = FETCH;
            FETCH: state_next = EXEC;
            EXEC:  state_next = OUT;
            OUT: begin
                if (res_ready) state_next = (remaining_reg == REM_ONE) ? IDLE : FETCH;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_reg        <= '0;
            remaining_reg  <= '0;
            instr_reg      <= '0;
            result_reg     <= '0;
            res_opcode_reg <= ZERO;
            res_ptr_reg    <= '0;
            dbz_reg        <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (launch) begin
                        ptr_reg       <= start_ptr;
                        remaining_reg <= count;
                    end
                end
                FETCH: instr_reg <= instruction_word;
                EXEC: begin
                    result_reg     <= alu_result;
                    res_opcode_reg <= instr_reg.opc;
                    res_ptr_reg    <= ptr_reg;
                    dbz_reg        <= alu_dbz;
                end
                OUT: begin
                    if (res_ready) begin
                        if (remaining_reg == REM_ONE) begin
                            done_reg <= 1'b1;
                        end else begin
                            remaining_reg <= remaining_reg - REM_ONE;
                            // Pointer wraps naturally at 2^PTR_W.
                            ptr_reg       <= ptr_reg + PTR_ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign read_pointer = ptr_reg;
    assign result       = result_reg;
    assign res_opcode   = res_opcode_reg;
    assign res_ptr      = res_ptr_reg;
    assign div_by_zero  = dbz_reg;
    assign res_valid    = (state_reg == OUT);
    assign busy         = (state_reg != IDLE);
    assign done         = done_reg;

endmodule

// File: doc/instr_exec.md
INSTR_EXEC -- requirements
Module: instr_exec

Interface
REQ-001 The block SHALL have parameter PTR_W, default 5: instruction-register pointer width (32 entries).
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port start  input  1  request to execute a batch; sampled only in IDLE.
REQ-005 The block SHALL have port start_ptr  input  PTR_W  first register entry of the batch.
REQ-006 The block SHALL have port count  input  PTR_W+1  number of instructions, 1..32.
REQ-007 The block SHALL have port read_pointer  output  PTR_W  address driven to the upstream instr_register.
REQ-008 The block SHALL have port instruction_word  input  instruction_t  combinational read data at read_pointer.
REQ-009 The block SHALL have port result  output  64 signed  computed result.
REQ-010 The block SHALL have port res_opcode  output  opcode_t  opcode of the presented result.
REQ-011 The block SHALL have port res_ptr  output  PTR_W  register entry that produced the result.
REQ-012 The block SHALL have port div_by_zero  output  1  qualifies result; DIV/MOD with op_b == 0.
REQ-013 The block SHALL have port res_valid  output  1  result bundle valid.
REQ-014 The block SHALL have port res_ready  input  1  consumer accepts the bundle.
REQ-015 The block SHALL have port busy  output  1  high in any state other than IDLE.
REQ-016 The block SHALL have port done  output  1  one-cycle pulse after the last handshake of a batch.

Function
REQ-017 The FSM SHALL have states IDLE, FETCH, EXEC, OUT.
REQ-018 In IDLE with start=1 and count != 0: latch start_ptr and count, then go to FETCH; start with count == 0 SHALL be ignored.
REQ-019 start while busy SHALL be ignored; the batch in progress is unaffected.
REQ-020 FETCH: read_pointer = current pointer; capture instruction_word into an internal register; next state EXEC.
REQ-021 EXEC: compute from the captured word and register result, res_opcode, res_ptr and div_by_zero; next state OUT.
REQ-022 OUT: res_valid=1; bundle held stable until res_valid && res_ready.
REQ-023 On handshake with remaining > 1: decrement remaining, pointer = pointer+1 modulo 2^PTR_W (31 -> 0), go to FETCH.
REQ-024 On handshake with remaining == 1: go to IDLE and assert done for exactly one cycle.
REQ-025 Minimum latency SHALL be 3 cycles per instruction: start/FETCH to res_valid in 2 cycles; handshake to next res_valid in 3 cycles.
REQ-026 Arithmetic SHALL be performed on 32-bit signed operands, sign-extended to 64 bits.
REQ-027 ZERO SHALL produce 0; PASSA op_a; PASSB op_b; ADD a+b; SUB a-b; MULT a*b (full 64-bit).
REQ-028 DIV SHALL truncate toward zero; MOD SHALL take the sign of the dividend.
REQ-029 DIV/MOD with op_b == 0 SHALL produce result 0 and div_by_zero=1; otherwise div_by_zero=0.
REQ-030 An undefined opcode encoding SHALL produce result 0.

Reset
REQ-031 reset_n low SHALL asynchronously force IDLE, abort any batch, and clear result, res_opcode (ZERO), res_ptr, div_by_zero, res_valid, busy, done and read_pointer to 0.
REQ-032 No done pulse SHALL be generated for a batch aborted by reset.

Configuration
REQ-033 With macro INSTR_EXEC_DIV_EN defined, DIV and MOD SHALL behave per REQ-028/029.
REQ-034 Without INSTR_EXEC_DIV_EN, DIV and MOD SHALL produce result 0 and div_by_zero=0, and no divider logic SHALL be synthesised.

Structure
REQ-035 opcode_t, operand_t, instruction_t and a 64-bit signed result_t SHALL come from instr_register_pkg; result_t SHALL be added there.
REQ-036 The arithmetic SHALL be one combinational sub-module, instr_alu (instruction_t in; result_t and div_by_zero out); the FSM and registers SHALL stay in instr_exec.

Verification
REQ-037 Register 3 = {ADD, 7, -3}; start, start_ptr=3, count=1 -> res_valid 2 cycles later, result=4, res_ptr=3, done one cycle after the handshake.
REQ-038 Register 31 = MULT 100000*100000, register 0 = SUB 5-9; start_ptr=31, count=2 -> results 10000000000 then -4; read_pointer wraps 31 -> 0.
REQ-039 DIV -7/2 and MOD -7/2 -> results -3 and -1; DIV 5/0 -> result 0 with div_by_zero=1. Without the macro, all three give result 0 and div_by_zero=0.
REQ-040 Hold res_ready=0 for 5 cycles in OUT -> bundle stable, no pointer advance; a start pulse during this window is ignored.
REQ-041 Assert reset_n low while in EXEC of a 4-instruction batch -> outputs 0 immediately, IDLE, no done; a fresh start afterwards runs normally.
